// File: rtl/gigatron_pkg.sv
// Shared encodings for the Gigatron-ISA core: instruction fields, branch modes, ctrl bit
// positions and the logical-to-physical RAM address mapping.
package gigatron_pkg;

    typedef enum logic [2:0] {
        OpLd  = 3'd0,
        OpAnd = 3'd1,
        OpOr  = 3'd2,
        OpXor = 3'd3,
        OpAdd = 3'd4,
        OpSub = 3'd5,
        OpSt  = 3'd6,
        OpBcc = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BusD   = 2'd0,
        BusRam = 2'd1,
        BusAc  = 2'd2,
        BusIn  = 2'd3
    } bus_e;

    // Destination-selecting modes for ALU ops and stores
    localparam logic [2:0] ModeDstX   = 3'd4;
    localparam logic [2:0] ModeDstY   = 3'd5;
    localparam logic [2:0] ModeDstOut = 3'd6;
    localparam logic [2:0] ModeOutInc = 3'd7;

    localparam logic [2:0] BrJmp = 3'd0;
    localparam logic [2:0] BrGt  = 3'd1;
    localparam logic [2:0] BrLt  = 3'd2;
    localparam logic [2:0] BrNe  = 3'd3;
    localparam logic [2:0] BrEq  = 3'd4;
    localparam logic [2:0] BrGe  = 3'd5;
    localparam logic [2:0] BrLe  = 3'd6;
    localparam logic [2:0] BrBra = 3'd7;

    localparam int unsigned CtrlSsLo   = 2;
    localparam int unsigned CtrlSsHi   = 5;
    localparam int unsigned CtrlBankLo = 6;
    localparam int unsigned CtrlBankHi = 7;

    // Upper 32K of the logical space is windowed onto one of four 32K physical banks.
    function automatic logic [16:0] phys_addr(input logic [15:0] laddr,
                                              input logic [1:0]  bank,
                                              input logic        banked);
        if (banked && laddr[15]) begin
            return {bank, laddr[14:0]};
        end
        return {1'b0, laddr};
    endfunction

endpackage

// File: rtl/gigatron_alu_cond.sv
// Combinational ALU result and branch-taken decision for the Gigatron core.
module gigatron_alu_cond
    import gigatron_pkg::*;
(
    input  op_e        i_op,
    input  logic [2:0] i_mode,
    input  logic [7:0] i_ac,
    input  logic [7:0] i_b,
    output logic [7:0] o_alu,
    output logic       o_take
);

    logic [7:0] w_zac;
    logic       w_gt;
    logic       w_lt;
    logic       w_eq;

    always_comb begin
        o_alu = i_b;
        case (i_op)
            OpAnd:   o_alu = i_ac & i_b;
            OpOr:    o_alu = i_ac | i_b;
            OpXor:   o_alu = i_ac ^ i_b;
            OpAdd:   o_alu = i_ac + i_b;
            OpSub:   o_alu = i_ac - i_b;
            default: o_alu = i_b;
        endcase
    end

    // Flipping the sign bit turns a signed test against zero into an unsigned one against 0x80
    assign w_zac = {~i_ac[7], i_ac[6:0]};
    assign w_gt  = w_zac > 8'h80;
    assign w_lt  = w_zac < 8'h80;
    assign w_eq  = w_zac == 8'h80;

    always_comb begin
        o_take = 1'b1;
        case (i_mode)
            BrGt:    o_take = w_gt;
            BrLt:    o_take = w_lt;
            BrNe:    o_take = ~w_eq;
            BrEq:    o_take = w_eq;
            BrGe:    o_take = w_gt | w_eq;
            BrLe:    o_take = w_lt | w_eq;
            default: o_take = 1'b1;
        endcase
    end

endmodule

// File: rtl/gigatron_core_ext.sv
// Gigatron-ISA core: one instruction per cycle with a branch delay slot, memory stall
// handshake, debug halt/single-step and optional 128K RAM banking via ctrl[7:6].
module gigatron_core_ext
    import gigatron_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter bit              BANKED   = 1'b1,
    parameter logic [7:0]      CTRL_RST = 8'h7C
) (
    input  logic            i_clock,
    input  logic            i_rst,
    output logic [PC_W-1:0] o_pc,
    input  logic [15:0]     i_rom,
    output logic [16:0]     o_addr_r,
    output logic [16:0]     o_addr_w,
    input  logic [7:0]      i_data,
    output logic [7:0]      o_data,
    output logic            o_we,
    input  logic            i_mem_ready,
    input  logic            i_halt,
    input  logic            i_step,
    output logic            o_halted,
    input  logic [7:0]      i_inreg,
    output logic [7:0]      o_out,
    output logic [7:0]      o_outx,
    output logic [7:0]      o_ctrl
);

    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [7:0]      r_ac, r_x, r_y, r_out, r_outx, r_ctrl, r_data_o;
    logic [16:0]     r_addr_w;
    logic            r_we, r_halted;

    op_e             w_op;
    logic [2:0]      w_mode;
    bus_e            w_bus;
    logic [7:0]      w_d;
    logic [15:0]     w_laddr;
    logic [16:0]     w_paddr;
    logic [7:0]      w_b;
    logic [7:0]      w_alu;
    logic            w_take;
    logic [7:0]      w_pc_hi;
    logic [15:0]     w_tgt;
    logic [PC_W-1:0] w_pc_next;
    logic            w_advance;

    assign w_op   = op_e'(r_ir[15:13]);
    assign w_mode = r_ir[12:10];
    assign w_bus  = bus_e'(r_ir[9:8]);
    assign w_d    = r_ir[7:0];

    always_comb begin
        w_laddr = {8'h00, w_d};
        if (w_op != OpBcc) begin
            case (w_mode)
                3'd1:       w_laddr = {8'h00, r_x};
                3'd2:       w_laddr = {r_y, w_d};
                3'd3, 3'd7: w_laddr = {r_y, r_x};
                default:    w_laddr = {8'h00, w_d};
            endcase
        end
    end

    assign w_paddr = phys_addr(w_laddr, r_ctrl[CtrlBankHi:CtrlBankLo], BANKED);

    always_comb begin
        case (w_bus)
            BusD:    w_b = w_d;
            BusRam:  w_b = i_data;
            BusAc:   w_b = r_ac;
            default: w_b = i_inreg;
        endcase
    end

    gigatron_alu_cond u_alu_cond (
        .i_op   (w_op),
        .i_mode (w_mode),
        .i_ac   (r_ac),
        .i_b    (w_b),
        .o_alu  (w_alu),
        .o_take (w_take)
    );

    // Short-branch high byte is the page of the delay-slot instruction
    assign w_pc_hi   = (w_mode == BrJmp) ? r_y : 8'(r_pc >> 8);
    assign w_tgt     = {w_pc_hi, w_b};
    assign w_pc_next = (w_op == OpBcc && w_take) ? PC_W'(w_tgt) : r_pc + PC_W'(1);
    assign w_advance = ~i_rst & i_mem_ready & (~r_halted | i_step);

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= 16'h0000;
            r_ac     <= 8'h00;
            r_x      <= 8'h00;
            r_y      <= 8'h00;
            r_out    <= 8'h00;
            r_outx   <= 8'h00;
            r_ctrl   <= CTRL_RST;
            r_we     <= 1'b0;
            r_addr_w <= 17'h0;
            r_data_o <= 8'h00;
            r_halted <= 1'b0;
        end else begin
            r_halted <= i_halt;
            r_we     <= 1'b0;
            if (w_advance) begin
                r_ir <= i_rom;
                r_pc <= w_pc_next;
                case (w_op)
                    OpSt: begin
                        r_addr_w <= w_paddr;
                        r_data_o <= w_b;
                        if (w_bus == BusRam) begin
                            r_ctrl <= w_d;
                        end else begin
                            r_we <= 1'b1;
                        end
                        if (w_mode == ModeDstX) r_x <= w_b;
                        if (w_mode == ModeDstY) r_y <= w_b;
                    end
                    OpBcc: ;
                    default: begin
                        case (w_mode)
                            ModeDstX: r_x <= w_alu;
                            ModeDstY: r_y <= w_alu;
                            ModeDstOut, ModeOutInc: begin
                                r_out <= w_alu;
                                // Rising edge of out[6] latches the pre-instruction ac
                                if (!r_out[6] && w_alu[6]) r_outx <= r_ac;
                            end
                            default: r_ac <= w_alu;
                        endcase
                    end
                endcase
                if (w_op != OpBcc && w_mode == ModeOutInc && w_bus == BusRam) begin
                    r_x <= r_x + 8'd1;
                end
            end
        end
    end

    assign o_pc     = r_pc;
    assign o_addr_r = w_paddr;
    assign o_addr_w = r_addr_w;
    assign o_data   = r_data_o;
    assign o_we     = r_we;
    assign o_halted = r_halted;
    assign o_out    = r_out;
    assign o_outx   = r_outx;
    assign o_ctrl   = r_ctrl;

endmodule

// File: tb/tb_gigatron_core_ext.sv
// Bench for gigatron_core_ext: directed vector table plus random stimulus against an ISA model.
module tb_gigatron_core_ext;

    logic        clk;
    logic        i_rst, i_mem_ready, i_halt, i_step;
    logic [15:0] i_rom;
    logic [7:0]  i_data, i_inreg;
    logic [15:0] o_pc;
    logic [16:0] o_addr_r, o_addr_w;
    logic [7:0]  o_data, o_out, o_outx, o_ctrl;
    logic        o_we, o_halted;

    int n_pass  = 0;
    int n_total = 0;

    gigatron_core_ext #(
        .PC_W     (16),
        .RESET_PC (16'h0000),
        .BANKED   (1'b1),
        .CTRL_RST (8'h7C)
    ) dut (
        .i_clock     (clk),
        .i_rst       (i_rst),
        .o_pc        (o_pc),
        .i_rom       (i_rom),
        .o_addr_r    (o_addr_r),
        .o_addr_w    (o_addr_w),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_we        (o_we),
        .i_mem_ready (i_mem_ready),
        .i_halt      (i_halt),
        .i_step      (i_step),
        .o_halted    (o_halted),
        .i_inreg     (i_inreg),
        .o_out       (o_out),
        .o_outx      (o_outx),
        .o_ctrl      (o_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural model state, plain integers
    int          m_pc, m_ac, m_x, m_y, m_out, m_outx, m_ctrl, m_addr_w, m_data_o;
    logic [15:0] m_ir;
    bit          m_we, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int m_phys();
        int mode = int'(m_ir[12:10]);
        int d    = int'(m_ir[7:0]);
        int la;
        if (m_ir[15:13] == 3'd7 || mode == 0 || (mode >= 4 && mode <= 6)) la = d;
        else if (mode == 1) la = m_x;
        else if (mode == 2) la = m_y * 256 + d;
        else la = m_y * 256 + m_x;
        if (la >= 32768) return (m_ctrl / 64) * 32768 + (la - 32768);
        return la;
    endfunction

    task automatic model_step(input bit rst, input bit rdy, input bit hlt, input bit stp,
                              input int rom, input int din, input int inreg);
        int op, mode, bus, d, b, res, pa, nxt, sac;
        bit take;
        if (rst) begin
            m_pc = 0; m_ir = 16'h0; m_ac = 0; m_x = 0; m_y = 0; m_out = 0; m_outx = 0;
            m_ctrl = 8'h7C; m_we = 0; m_addr_w = 0; m_data_o = 0; m_halted = 0;
            return;
        end
        m_we = 0;
        if (rdy && (!m_halted || stp)) begin
            op   = int'(m_ir[15:13]);
            mode = int'(m_ir[12:10]);
            bus  = int'(m_ir[9:8]);
            d    = int'(m_ir[7:0]);
            pa   = m_phys();
            b    = (bus == 0) ? d : (bus == 1) ? din : (bus == 2) ? m_ac : inreg;
            nxt  = (m_pc + 1) % 65536;
            if (op < 6) begin
                case (op)
                    0:       res = b;
                    1:       res = m_ac & b;
                    2:       res = m_ac | b;
                    3:       res = m_ac ^ b;
                    4:       res = (m_ac + b) % 256;
                    default: res = (m_ac - b + 256) % 256;
                endcase
                if (mode < 4) m_ac = res;
                else if (mode == 4) m_x = res;
                else if (mode == 5) m_y = res;
                else begin
                    if ((m_out & 64) == 0 && (res & 64) != 0) m_outx = m_ac;
                    m_out = res;
                end
            end else if (op == 6) begin
                m_addr_w = pa;
                m_data_o = b;
                if (bus == 1) m_ctrl = d;
                else m_we = 1;
                if (mode == 4) m_x = b;
                if (mode == 5) m_y = b;
            end else begin
                sac = (m_ac >= 128) ? m_ac - 256 : m_ac;
                case (mode)
                    1:       take = sac > 0;
                    2:       take = sac < 0;
                    3:       take = sac != 0;
                    4:       take = sac == 0;
                    5:       take = sac >= 0;
                    6:       take = sac <= 0;
                    default: take = 1;
                endcase
                if (take) nxt = ((mode == 0) ? m_y : m_pc / 256) * 256 + b;
            end
            if (op != 7 && mode == 7 && bus == 1) m_x = (m_x + 1) % 256;
            m_ir = 16'(rom);
            m_pc = nxt;
        end
        m_halted = hlt;
    endtask

    task automatic compare_model();
        chk("model_pc", o_pc, m_pc);
        chk("model_addr_r", o_addr_r, m_phys());
        chk("model_addr_w", o_addr_w, m_addr_w);
        chk("model_data_o", o_data, m_data_o);
        chk("model_we", o_we, m_we);
        chk("model_halted", o_halted, m_halted);
        chk("model_out", o_out, m_out);
        chk("model_outx", o_outx, m_outx);
        chk("model_ctrl", o_ctrl, m_ctrl);
    endtask

    task automatic cycle(input bit rst, input bit rdy, input bit hlt, input bit stp,
                         input logic [15:0] rom, input logic [7:0] din, input logic [7:0] inreg);
        i_rst = rst; i_mem_ready = rdy; i_halt = hlt; i_step = stp;
        i_rom = rom; i_data = din; i_inreg = inreg;
        @(posedge clk);
        model_step(rst, rdy, hlt, stp, int'(rom), int'(din), int'(inreg));
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          rst, rdy, hlt, stp;
        logic [15:0] rom;
        logic [7:0]  din;
        logic [15:0] pc;
        bit          we;
        logic [16:0] aw;
        logic [7:0]  dout, out, outx, ctrl;
        bit          halted;
    } vec_t;

    function automatic vec_t v(bit rst, bit rdy, bit hlt, bit stp, logic [15:0] rom,
                               logic [7:0] din, logic [15:0] pc, bit we, logic [16:0] aw,
                               logic [7:0] dout, logic [7:0] out, logic [7:0] outx,
                               logic [7:0] ctrl, bit halted);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.hlt = hlt; r.stp = stp; r.rom = rom; r.din = din;
        r.pc = pc; r.we = we; r.aw = aw; r.dout = dout; r.out = out; r.outx = outx;
        r.ctrl = ctrl; r.halted = halted;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        bit   hlt;
        i_rst = 1'b1; i_mem_ready = 1'b1; i_halt = 1'b0; i_step = 1'b0;
        i_rom = 16'h0; i_data = 8'h0; i_inreg = 8'h0;

        // rst rdy hlt stp rom din | pc we addr_w data_o out outx ctrl halted
        tbl.push_back(v(1, 1, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h0055, 8'h00, 16'h0001, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h80AB, 8'h00, 16'h0002, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1A00, 8'h00, 16'h0003, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h003C, 8'h00, 16'h0004, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1840, 8'h00, 16'h0005, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1840, 8'h00, 16'h0006, 0, 17'h00000, 8'h00, 8'h40, 8'h3C, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1490, 8'h00, 16'h0007, 0, 17'h00000, 8'h00, 8'h40, 8'h3C, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hC180, 8'h00, 16'h0008, 0, 17'h00000, 8'h00, 8'h40, 8'h3C, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hCA10, 8'h00, 16'h0009, 0, 17'h00080, 8'h00, 8'h40, 8'h3C, 8'h80, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hC910, 8'h00, 16'h000A, 1, 17'h11010, 8'h3C, 8'h40, 8'h3C, 8'h80, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hCA20, 8'h77, 16'h000B, 0, 17'h11010, 8'h77, 8'h40, 8'h3C, 8'h10, 0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(v(0, 0, 0, 0, 16'h0000, 8'h00, 16'h000B, 0, 17'h11010, 8'h77, 8'h40, 8'h3C, 8'h10, 0));
        end
        tbl.push_back(v(0, 1, 0, 0, 16'h0000, 8'h00, 16'h000C, 1, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1401, 8'h00, 16'h000D, 0, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hE023, 8'h00, 16'h000E, 0, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h00FF, 8'h00, 16'h0123, 0, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hE840, 8'h00, 16'h0124, 0, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h1800, 8'h00, 16'h0140, 0, 17'h01020, 8'h3C, 8'h40, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h0000, 8'h00, 16'h0141, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hEC80, 8'h00, 16'h0142, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h0000, 8'h00, 16'h0143, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h0000, 8'h00, 16'h0144, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 0));
        tbl.push_back(v(0, 1, 1, 0, 16'h0000, 8'h00, 16'h0145, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 0, 16'h0000, 8'h00, 16'h0145, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 1, 16'h0000, 8'h00, 16'h0146, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 0, 16'h0000, 8'h00, 16'h0146, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 1, 16'h0000, 8'h00, 16'h0147, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 0, 1, 1, 16'h0000, 8'h00, 16'h0147, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 1, 16'h0000, 8'h00, 16'h0148, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(0, 1, 1, 0, 16'h0000, 8'h00, 16'h0148, 0, 17'h01020, 8'h3C, 8'h00, 8'h3C, 8'h10, 1));
        tbl.push_back(v(1, 1, 1, 0, 16'h0000, 8'h00, 16'h0000, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'hC000, 8'h00, 16'h0001, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(1, 1, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));
        tbl.push_back(v(0, 1, 0, 0, 16'h0000, 8'h00, 16'h0001, 0, 17'h00000, 8'h00, 8'h00, 8'h00, 8'h7C, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].rdy, tbl[i].hlt, tbl[i].stp, tbl[i].rom, tbl[i].din, 8'h00);
            chk($sformatf("vec%0d_pc", i), o_pc, tbl[i].pc);
            chk($sformatf("vec%0d_we", i), o_we, tbl[i].we);
            chk($sformatf("vec%0d_addr_w", i), o_addr_w, tbl[i].aw);
            chk($sformatf("vec%0d_data_o", i), o_data, tbl[i].dout);
            chk($sformatf("vec%0d_out", i), o_out, tbl[i].out);
            chk($sformatf("vec%0d_outx", i), o_outx, tbl[i].outx);
            chk($sformatf("vec%0d_ctrl", i), o_ctrl, tbl[i].ctrl);
            chk($sformatf("vec%0d_halted", i), o_halted, tbl[i].halted);
        end

        hlt = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) hlt = ~hlt;
            cycle($urandom_range(0, 255) == 0, $urandom_range(0, 7) != 0, hlt,
                  $urandom_range(0, 2) == 0, 16'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
